fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_buffer.sv | 87 ++++++++
 rtl/fetch_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch slice.
// Holds the fetch FSM encoding, the pc step, the default reset pc and the
// 64-bit buffer entry layout (pc in the upper half, instruction in the lower).
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        FULL  = 2'b01,
        HALT  = 2'b10
    } fetch_state_e;

    localparam logic [31:0] PC_INCREMENT     = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } buf_entry_t;

    // Memory control works in words, so the byte pc drops its two low bits.
    function automatic logic [31:0] wordAddress(input logic [31:0] byteAddr);
        return byteAddr >> 2;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: small synchronous FIFO holding fetched {pc, instruction} pairs.
// DEPTH must be a power of two (2 or 4) so the pointers wrap naturally.
// flush empties the FIFO and wins over a same-cycle push or pop.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int COUNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  buf_entry_t         wdata_i,
    output buf_entry_t         rdata_o,
    output logic [COUNT_W-1:0] count_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(DEPTH);

    logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    buf_entry_t         mem_q [DEPTH];

    logic doPush;
    logic doPop;

    // Qualify push/pop against occupancy and compute the next pointers and count.
    always_comb begin
        doPush  = push_i && !flush_i && ((count_q != COUNT_MAX) || pop_i);
        doPop   = pop_i && !flush_i && (count_q != '0);
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            if (doPush && !doPop) begin
                count_d = count_q + COUNT_W'(1);
            end else if (!doPush && doPop) begin
                count_d = count_q - COUNT_W'(1);
            end
        end
    end

    // Pointer and occupancy registers; reset leaves the FIFO empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

    // Head entry and status flags seen by the fetch control.
    always_comb begin
        rdata_o = mem_q[rdPtr_q];
        count_o = count_q;
        full_o  = (count_q == COUNT_MAX);
        empty_o = (count_q == '0);
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with a small decoupling buffer.
// At most one memory read is outstanding; each response is tagged with a 1-bit
// epoch so that a redirect silently discards any word still in flight.
// Optional feature: define FETCH_MISALIGN_TRAP_EN to halt on a misaligned
// redirect and expose the sticky misalign_trap output. Without it the low two
// bits of redirect_pc are dropped.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] mem_address,
    output logic        mem_op_if,
    input  logic        mem_wait_if,
    input  logic [31:0] mem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        misalign_trap
`endif
);

    localparam int COUNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [COUNT_W:0] DEPTH_LIMIT = (COUNT_W + 1)'(BUF_DEPTH);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         inFlight_q, inFlight_d;
    logic         flightEpoch_q, flightEpoch_d;
    logic         epoch_q, epoch_d;

    logic               takeRedirect;
    logic               misalignRedirect;
    logic [31:0]        redirectTarget;
    logic               liveResponse;
    logic               bufPush;
    logic               bufPop;
    logic               bufFlush;
    logic [31:0]        fetchPc;
    logic [COUNT_W:0]   nextCount;
    logic               issueReq;
    logic [COUNT_W-1:0] bufCount;
    logic               bufFull;
    logic               bufEmpty;
    buf_entry_t         pushEntry;
    buf_entry_t         headEntry;

    // Datapath decisions for this cycle: redirect, response capture, pop and request issue.
    always_comb begin
`ifdef FETCH_MISALIGN_TRAP_EN
        misalignRedirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
        misalignRedirect = 1'b0;
`endif
        redirectTarget = redirect_pc & ~32'h0000_0003;
        takeRedirect   = redirect_valid && (state_q != HALT);
        liveResponse   = inFlight_q && (flightEpoch_q == epoch_q);
        bufPop         = !bufEmpty && inst_ready;
        bufPush        = liveResponse && !mem_wait_if && !takeRedirect
                         && (state_q != HALT) && (!bufFull || bufPop);
        bufFlush       = takeRedirect;
        pushEntry      = '{pc: pc_q, inst: mem_data};
        fetchPc        = bufPush ? (pc_q + PC_INCREMENT) : pc_q;
        nextCount      = {1'b0, bufCount}
                         + {{COUNT_W{1'b0}}, bufPush}
                         - {{COUNT_W{1'b0}}, bufPop};
        issueReq       = rst_n && (state_q == FETCH) && (nextCount < DEPTH_LIMIT);
    end

    // Next-state logic for the fetch FSM, pc, in-flight tracking and epoch.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inFlight_d    = issueReq;
        flightEpoch_d = epoch_q;
        epoch_d       = epoch_q;
        if (bufPush) begin
            pc_d = pc_q + PC_INCREMENT;
        end
        case (state_q)
            FETCH: begin
                if (nextCount == DEPTH_LIMIT) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (bufPop) begin
                    state_d = FETCH;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
        if (takeRedirect) begin
            epoch_d = ~epoch_q;
            pc_d    = redirectTarget;
            state_d = misalignRedirect ? HALT : FETCH;
        end
    end

    // Control state registers; reset discards any response still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            inFlight_q    <= 1'b0;
            flightEpoch_q <= 1'b0;
            epoch_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inFlight_q    <= inFlight_d;
            flightEpoch_q <= flightEpoch_d;
            epoch_q       <= epoch_d;
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) uBuffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (bufPush),
        .pop_i   (bufPop),
        .flush_i (bufFlush),
        .wdata_i (pushEntry),
        .rdata_o (headEntry),
        .count_o (bufCount),
        .full_o  (bufFull),
        .empty_o (bufEmpty)
    );

    // Outputs; the head is forced to zero whenever nothing valid is presented.
    always_comb begin
        mem_op_if   = issueReq;
        mem_address = wordAddress(fetchPc);
        inst_valid  = !bufEmpty;
        inst_data   = bufEmpty ? 32'h0 : headEntry.inst;
        inst_pc     = bufEmpty ? 32'h0 : headEntry.pc;
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic trap_q, trap_d;

    // Sticky trap flag, cleared only by reset.
    always_comb begin
        trap_d = trap_q | (takeRedirect & misalignRedirect);
    end

    // Trap flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= trap_d;
        end
    end

    assign misalign_trap = trap_q;
`endif

endmodule
